// File: rtl/vec_alu_issue.sv
// Decode/issue stage for the vector ALU: decodes one instruction and issues one beat
// per lane group. Define VEC_ALU_ISSUE_ILLEGAL_TRAP_EN to make illegal opcodes a sticky trap.
module vec_alu_issue #(
  parameter int INSTR_W  = 32,
  parameter int LANES    = 2,
  parameter int VLEN_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_W-1:0]            instr,
  input  logic [$clog2(VLEN_MAX+1)-1:0] vlen,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2:0]                    alu_op,
  output logic [3:0]                    rd,
  output logic [3:0]                    rs1,
  output logic [3:0]                    rs2,
  output logic [13:0]                   imm,
  output logic                          use_imm,
  output logic                          wr_en,
  output logic                          flags_wr,
  output logic [$clog2(VLEN_MAX)-1:0]   elem_base,
  output logic                          last,
  output logic                          illegal
);

  localparam int VW = $clog2(VLEN_MAX + 1);
  localparam int EW = $clog2(VLEN_MAX);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_MOV = 3'b001, OP_XOR = 3'b010, OP_OR  = 3'b011,
    OP_SHR = 3'b100, OP_SHL = 3'b101, OP_CMP = 3'b110, OP_SUB = 3'b111
  } alu_op_e;

  typedef enum logic { S_IDLE = 1'b0, S_ISSUE = 1'b1 } state_e;

  // Valid/ready: a transfer happens on a rising clk edge where valid & ready are both 1;
  // a producer holding valid keeps its payload stable until that edge.
  state_e        state, state_nxt;
  logic [4:0]    opcode;
  logic          vec;
  logic          dec_legal, dec_imm, dec_wr, dec_flags;
  alu_op_e       dec_op;
  logic [VW-1:0] vlen_clamp;
  logic [VW:0]   beat_cnt;
  logic [VW:0]   beats_left;
  logic          accept, fire, load;

  assign opcode = instr[31:27];
  assign vec    = instr[26];

  always_comb begin
    dec_legal = 1'b1;
    dec_op    = OP_ADD;
    dec_imm   = 1'b0;
    case (opcode)
      5'd0: dec_op = OP_ADD;
      5'd1: begin dec_op = OP_ADD; dec_imm = 1'b1; end
      5'd2: dec_op = OP_SUB;
      5'd3: dec_op = OP_MOV;
      5'd4: begin dec_op = OP_MOV; dec_imm = 1'b1; end
      5'd5: dec_op = OP_XOR;
      5'd6: dec_op = OP_OR;
      5'd7: begin dec_op = OP_SHL; dec_imm = 1'b1; end
      5'd8: begin dec_op = OP_SHR; dec_imm = 1'b1; end
      5'd9: dec_op = OP_CMP;
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_wr    = dec_legal && (dec_op != OP_CMP);
  assign dec_flags = dec_legal && ((dec_op == OP_CMP) || (dec_op == OP_SUB));

  // Vector lengths beyond VLEN_MAX are clamped; beats round up to whole lane groups.
  assign vlen_clamp = (vlen > VW'(VLEN_MAX)) ? VW'(VLEN_MAX) : vlen;
  assign beat_cnt   = vec ? (({1'b0, vlen_clamp} + (VW+1)'(LANES - 1)) / (VW+1)'(LANES))
                          : (VW+1)'(1);

  assign out_valid = (state == S_ISSUE);
  assign fire      = out_valid && out_ready;
  assign in_ready  = !illegal && ((state == S_IDLE) || (fire && last));
  assign accept    = in_valid && in_ready;
  // Illegal words and zero-length vectors are consumed without loading a beat.
  assign load      = accept && dec_legal && (beat_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load) state_nxt = S_ISSUE;
      S_ISSUE: if (fire && last) state_nxt = load ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op     <= OP_ADD;
      rd         <= '0;
      rs1        <= '0;
      rs2        <= '0;
      imm        <= '0;
      use_imm    <= 1'b0;
      wr_en      <= 1'b0;
      flags_wr   <= 1'b0;
      elem_base  <= '0;
      last       <= 1'b0;
      beats_left <= '0;
    end else if (load) begin
      alu_op     <= dec_op;
      rd         <= instr[25:22];
      rs1        <= instr[21:18];
      rs2        <= instr[17:14];
      imm        <= instr[13:0];
      use_imm    <= dec_imm;
      wr_en      <= dec_wr;
      flags_wr   <= dec_flags;
      elem_base  <= '0;
      last       <= (beat_cnt == (VW+1)'(1));
      beats_left <= beat_cnt;
    end else if (fire && !last) begin
      elem_base  <= elem_base + EW'(LANES);
      beats_left <= beats_left - (VW+1)'(1);
      last       <= (beats_left == (VW+1)'(2));
    end
  end

`ifdef VEC_ALU_ISSUE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     illegal <= 1'b0;
    else if (accept && !dec_legal)  illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_vec_alu_issue.sv
// Directed bench for vec_alu_issue: expected beats are queued at issue and checked
// by an independent monitor whenever a beat transfers.
module tb_vec_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [3:0]  vlen = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  alu_op;
  logic [3:0]  rd, rs1, rs2;
  logic [13:0] imm;
  logic        use_imm, wr_en, flags_wr;
  logic [2:0]  elem_base;
  logic        last, illegal;

  int n_vec  = 0;
  int n_fail = 0;
  logic [35:0] exp_q[$];

  vec_alu_issue #(.INSTR_W(32), .LANES(2), .VLEN_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .vlen(vlen), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .use_imm(use_imm), .wr_en(wr_en), .flags_wr(flags_wr),
    .elem_base(elem_base), .last(last), .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- helpers ----------------
  function automatic logic [31:0] mk(input logic [4:0] opc, input logic v, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2, input logic [13:0] im);
    return {opc, v, d, s1, s2, im};
  endfunction

  function automatic logic [35:0] beat(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1,
                                       input logic [3:0] s2, input logic [13:0] im, input logic ui,
                                       input logic we, input logic fw, input logic [2:0] eb, input logic ls);
    return {op, d, s1, s2, im, ui, we, fw, eb, ls};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge; returns just after the edge that accepted the word.
  task automatic send(input logic [31:0] w, input logic [3:0] vl);
    int  cyc = 0;
    bit  acc = 1'b0;
    in_valid = 1'b1;
    instr    = w;
    vlen     = vl;
    while (!acc && cyc < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {28'd0, alu_op, rd, rs1, rs2, imm, use_imm, wr_en, flags_wr, elem_base, last}, 64'hDEAD);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        check("beat", {28'd0, alu_op, rd, rs1, rs2, imm, use_imm, wr_en, flags_wr, elem_base, last}, {28'd0, e});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    @(negedge clk);
    check("reset_outputs", {28'd0, alu_op, rd, rs1, rs2, imm, use_imm, wr_en, flags_wr, elem_base, last},
          64'd0);
    check("reset_valid_illegal", {62'd0, out_valid, illegal}, 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // scalar ADD
    exp_q.push_back(beat(3'b000, 4'd3, 4'd1, 4'd2, 14'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1));
    send(mk(5'd0, 1'b0, 4'd3, 4'd1, 4'd2, 14'd0), 4'd0);
    @(negedge clk);
    check("add_latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    drain();

    // scalar CMP held under back-pressure
    out_ready = 1'b0;
    exp_q.push_back(beat(3'b110, 4'd5, 4'd6, 4'd7, 14'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1));
    send(mk(5'd9, 1'b0, 4'd5, 4'd6, 4'd7, 14'd0), 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cmp_stall_state", {58'd0, out_valid, in_ready, alu_op, wr_en, flags_wr, rd},
            {58'd0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 4'd5});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("cmp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drain();

    // vector SUB, vlen=8: four beats
    for (int i = 0; i < 4; i++)
      exp_q.push_back(beat(3'b111, 4'd4, 4'd8, 4'd9, 14'd0, 1'b0, 1'b1, 1'b1, 3'(2*i), 1'(i == 3)));
    send(mk(5'd2, 1'b1, 4'd4, 4'd8, 4'd9, 14'd0), 4'd8);
    drain();

    // vector XOR, vlen=5: three beats
    for (int i = 0; i < 3; i++)
      exp_q.push_back(beat(3'b010, 4'd1, 4'd2, 4'd3, 14'd0, 1'b0, 1'b1, 1'b0, 3'(2*i), 1'(i == 2)));
    send(mk(5'd5, 1'b1, 4'd1, 4'd2, 4'd3, 14'd0), 4'd5);
    drain();

    // vector OR, vlen=0: consumed with no beat
    send(mk(5'd6, 1'b1, 4'd1, 4'd1, 4'd1, 14'd0), 4'd0);
    @(negedge clk);
    check("vlen0_no_beat", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    @(posedge clk); #1;

    // vector ADDI, vlen=15 clamps to 8: four beats
    for (int i = 0; i < 4; i++)
      exp_q.push_back(beat(3'b000, 4'd2, 4'd3, 4'd0, 14'h0055, 1'b1, 1'b1, 1'b0, 3'(2*i), 1'(i == 3)));
    send(mk(5'd1, 1'b1, 4'd2, 4'd3, 4'd0, 14'h0055), 4'd15);
    drain();

    // remaining scalar decodes: MOV, OR, SHR
    exp_q.push_back(beat(3'b001, 4'd9, 4'd10, 4'd0, 14'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1));
    send(mk(5'd3, 1'b0, 4'd9, 4'd10, 4'd0, 14'd0), 4'd0);
    exp_q.push_back(beat(3'b011, 4'd11, 4'd12, 4'd13, 14'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1));
    send(mk(5'd6, 1'b0, 4'd11, 4'd12, 4'd13, 14'd0), 4'd0);
    exp_q.push_back(beat(3'b100, 4'd14, 4'd15, 4'd0, 14'd4, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1));
    send(mk(5'd8, 1'b0, 4'd14, 4'd15, 4'd0, 14'd4), 4'd0);
    drain();

    // back-to-back MOVI then SHL with no bubble
    exp_q.push_back(beat(3'b001, 4'd6, 4'd0, 4'd0, 14'h1234, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1));
    send(mk(5'd4, 1'b0, 4'd6, 4'd0, 4'd0, 14'h1234), 4'd0);
    exp_q.push_back(beat(3'b101, 4'd7, 4'd7, 4'd0, 14'd3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1));
    send(mk(5'd7, 1'b0, 4'd7, 4'd7, 4'd0, 14'd3), 4'd0);
    @(negedge clk);
    check("b2b_no_bubble", {60'd0, out_valid, alu_op}, {60'd0, 1'b1, 3'b101});
    @(posedge clk); #1;
    drain();

    // reset asserted while beat 2 of a vlen=8 vector is presented
    exp_q.push_back(beat(3'b111, 4'd4, 4'd8, 4'd9, 14'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0));
    send(mk(5'd2, 1'b1, 4'd4, 4'd8, 4'd9, 14'd0), 4'd8);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset_abort_valid", {61'd0, out_valid, elem_base}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("after_abort_idle", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    end
    @(posedge clk); #1;

    // illegal opcode 0x1F
    send(mk(5'h1F, 1'b0, 4'd1, 4'd2, 4'd3, 14'd0), 4'd0);
`ifdef VEC_ALU_ISSUE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("illegal_trap", {61'd0, illegal, in_ready, out_valid}, {61'd0, 1'b1, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    do_reset();
    @(negedge clk);
    check("illegal_cleared", {62'd0, illegal, in_ready}, {62'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
`else
    @(negedge clk);
    check("illegal_nop", {61'd0, illegal, in_ready, out_valid}, {61'd0, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
`endif
    exp_q.push_back(beat(3'b000, 4'd10, 4'd11, 4'd12, 14'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1));
    send(mk(5'd0, 1'b0, 4'd10, 4'd11, 4'd12, 14'd0), 4'd0);
    drain();

    repeat (3) @(posedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_alu_issue.md
Name: vec_alu_issue

Overview:
- Instruction-decode/issue stage that produces the 3-bit ALU operation codes (ADD=000, MOV=001, XOR=010, OR=011, SHR=100, SHL=101, CMP=110, SUB=111) plus operand controls for the vector ALU.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them.
- Scalar instructions issue one beat; vector instructions issue one beat per lane group until the vector length is covered.
- Sits between fetch and the register-read/ALU stage.

Parameters:
- INSTR_W, 32, instruction word width; fixed field layout below.
- LANES, 2, elements processed per issued beat.
- VLEN_MAX, 8, maximum vector length in elements; must be a multiple of LANES.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept an instruction
- instr  in  INSTR_W  instruction word
- vlen  in  $clog2(VLEN_MAX+1)  current vector length; sampled at acceptance
- out_valid  out  1  issued beat valid
- out_ready  in  1  downstream accepts beat
- alu_op  out  3  ALU operation code
- rd, rs1, rs2  out  4 each  register indices
- imm  out  14  immediate, zero-extended downstream
- use_imm  out  1  operand B is imm
- wr_en  out  1  writeback enable
- flags_wr  out  1  update flags
- elem_base  out  $clog2(VLEN_MAX)  first element index of this beat
- last  out  1  final beat of the instruction
- illegal  out  1  illegal opcode indicator

Behaviour:
- Instruction fields:
  - instr[31:27] = opcode; instr[26] = vector flag.
  - rd = [25:22], rs1 = [21:18], rs2 = [17:14], imm = [13:0].
- Opcode decode (opcode -> alu_op, use_imm):
  - 00 -> ADD, 0; 01 -> ADD, 1 (ADDI)
  - 02 -> SUB, 0
  - 03 -> MOV, 0; 04 -> MOV, 1 (MOVI)
  - 05 -> XOR, 0; 06 -> OR, 0
  - 07 -> SHL, 1; 08 -> SHR, 1
  - 09 -> CMP, 0
  - all other opcodes are illegal.
- Writeback and flags:
  - wr_en = 1 for all legal ops except CMP.
  - flags_wr = 1 for CMP and SUB.
- FSM states: IDLE, ISSUE.
  - in_ready = 1 only in IDLE with no held beat, or when the held beat is being accepted and it is last.
- Acceptance (in_valid & in_ready):
  - Legal op: fields latch, state moves to ISSUE, out_valid rises next cycle. Latency accept -> out_valid is 1 cycle.
  - Beat count: scalar = 1; vector = ceil(min(vlen, VLEN_MAX) / LANES). vlen above VLEN_MAX is clamped.
  - Vector with vlen = 0: consumed with no beat issued; state stays IDLE.
- Beat sequencing in ISSUE:
  - elem_base starts at 0 and advances by LANES on each out_valid & out_ready.
  - last = 1 on the final beat; scalar beats have elem_base = 0, last = 1.
  - On acceptance of the last beat, return to IDLE, or load the next instruction in the same cycle if one is accepted back-to-back (zero-bubble).
- Output stability: while out_valid & !out_ready, every output is held stable.
- Reset: asynchronous; state = IDLE.
  - out_valid, wr_en, flags_wr, use_imm, last, illegal = 0.
  - alu_op = ADD (000); rd, rs1, rs2, imm, elem_base = 0.
  - Reset asserted mid-vector aborts the sequence; no further beats are issued.
- vlen is sampled only at acceptance; changes during ISSUE are ignored.

Optional Feature:
- Macro: VEC_ALU_ISSUE_ILLEGAL_TRAP_EN
- Defined:
  - An illegal opcode is consumed and sets illegal = 1 the next cycle; illegal is sticky.
  - While illegal = 1, in_ready = 0. Only rst_n clears it.
  - No beat is issued for the illegal word.
- Undefined:
  - Illegal opcodes are consumed silently as NOPs with no beat; illegal is tied 0.

Test Plan:
- Reset then scalar ADD: instr opcode 00, rd=3, rs1=1, rs2=2, out_ready=1 -> one cycle later out_valid=1, alu_op=000, wr_en=1, flags_wr=0, last=1, elem_base=0.
- Scalar CMP with out_ready=0 for 3 cycles -> alu_op=110, wr_en=0, flags_wr=1, all outputs stable, in_ready=0; then out_ready=1 -> beat taken, in_ready=1.
- Vector SUB, vlen=8, LANES=2, out_ready=1 -> 4 beats, elem_base 0, 2, 4, 6, alu_op=111, last only on elem_base=6; vector with vlen=5 -> 3 beats; vlen=0 -> no beat, in_ready stays 1.
- Back-to-back: MOVI (opcode 04, imm=0x1234) followed immediately by SHL (opcode 07) with out_ready=1 -> consecutive beats with no bubble: alu_op 001 then 101, use_imm=1 both, imm=0x1234 on the first.
- Reset asserted on beat 2 of a vlen=8 vector -> out_valid=0 immediately, state IDLE, no further beats after release.
- Opcode 0x1F:
  - With VEC_ALU_ISSUE_ILLEGAL_TRAP_EN: illegal=1 next cycle, in_ready=0 until reset, no beat.
  - Without: no beat, illegal=0, the following ADD is accepted normally.
